// File: rtl/relnet_pkg.sv
// Shared relnet types: packet types, connection set types and per-slot GBN state.
package relnet_pkg;

  localparam int unsigned SLOT_FIELD_W = 10;
  localparam int unsigned SET_TYPE_W   = 6;
  localparam int unsigned PKT_TYPE_W   = 8;
  localparam int unsigned SEQ_MAX_W    = 32;

  typedef enum logic [PKT_TYPE_W-1:0] {
    PKT_ACK  = 8'd1,
    PKT_NACK = 8'd2,
    PKT_DATA = 8'd3,
    PKT_SYN  = 8'd4,
    PKT_FIN  = 8'd5
  } pkt_type_t;

  localparam logic [SET_TYPE_W-1:0] SET_OPEN  = 6'd1;
  localparam logic [SET_TYPE_W-1:0] SET_CLOSE = 6'd2;

  // exp is sized for the widest supported sequence; narrower trackers use the low bits.
  typedef struct packed {
    logic                 open;
    logic                 nack_sent;
    logic [SEQ_MAX_W-1:0] exp;
  } slot_state_t;

endpackage

// File: rtl/gbn_rx_seq_tracker_table.sv
// Per-slot connection state storage: one combinational read port, one write port.
module gbn_slot_table
  import relnet_pkg::*;
#(
  parameter int unsigned N_SLOTS = 64,
  parameter int unsigned SLOT_W  = $clog2(N_SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SLOT_W-1:0] rd_idx,
  output slot_state_t       rd_data,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_idx,
  input  slot_state_t       wr_data
);

  slot_state_t mem [N_SLOTS];

  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_SLOTS); i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/gbn_rx_seq_tracker.sv
// Multi-session go-back-N receive tracker: one accept/drop decision and at most
// one ACK/NACK request per incoming header, with per-slot state in gbn_slot_table.
module gbn_rx_seq_tracker
  import relnet_pkg::*;
#(
  parameter int unsigned N_SLOTS = 64,
  parameter int unsigned SLOT_W  = $clog2(N_SLOTS),
  parameter int unsigned SEQ_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             conn_set_valid,
  output logic             conn_set_ready,
  input  logic [15:0]      conn_set_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_slot,
  input  logic [SEQ_W-1:0] in_seq,
  input  logic [7:0]       in_type,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_slot,
  output logic             out_accept,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [9:0]       rsp_slot,
  output logic [SEQ_W-1:0] rsp_seq,
  output logic [7:0]       rsp_type
);

  logic [SLOT_FIELD_W-1:0] cs_slot;
  logic [SET_TYPE_W-1:0]   cs_type;
  logic                    cs_in_range;
  logic                    hdr_in_range;
  logic                    conn_fire;
  logic                    hdr_fire;
  logic                    is_seq_pkt;
  logic [SLOT_W-1:0]       tbl_idx;
  slot_state_t             rd_data;
  slot_state_t             wr_data;
  logic                    wr_en;
  logic [SEQ_W-1:0]        exp_cur;
  logic [SEQ_W-1:0]        d;
  logic                    dec_accept;
  logic                    rsp_need;
  logic [7:0]              rsp_type_n;
  logic [SEQ_W-1:0]        rsp_seq_n;

  assign cs_slot        = conn_set_data[15:6];
  assign cs_type        = conn_set_data[5:0];
  assign cs_in_range    = {1'b0, cs_slot} < 11'(N_SLOTS);
  assign hdr_in_range   = {1'b0, in_slot} < 11'(N_SLOTS);
  assign conn_set_ready = !rst;
  assign in_ready       = !rst && !conn_set_valid && (!out_valid || out_ready) &&
                          (!rsp_valid || rsp_ready);
  assign conn_fire      = conn_set_valid && conn_set_ready;
  assign hdr_fire       = in_valid && in_ready;
  assign is_seq_pkt     = (in_type == 8'(PKT_DATA)) || (in_type == 8'(PKT_FIN));

  // Connection requests own the single read/write port in their cycle.
  assign tbl_idx = conn_set_valid ? SLOT_W'(cs_slot) : SLOT_W'(in_slot);
  assign exp_cur = rd_data.exp[SEQ_W-1:0];
  assign d       = in_seq - exp_cur;

  gbn_slot_table #(
    .N_SLOTS(N_SLOTS),
    .SLOT_W (SLOT_W)
  ) u_table (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (tbl_idx),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_idx (tbl_idx),
    .wr_data(wr_data)
  );

  // Decision and next slot state.
  always_comb begin
    wr_en      = 1'b0;
    wr_data    = rd_data;
    dec_accept = 1'b0;
    rsp_need   = 1'b0;
    rsp_type_n = 8'(PKT_ACK);
    rsp_seq_n  = in_seq;
    if (conn_fire) begin
      if (cs_in_range && cs_type == SET_OPEN) begin
        wr_en             = 1'b1;
        wr_data.open      = 1'b1;
        wr_data.nack_sent = 1'b0;
        wr_data.exp       = SEQ_MAX_W'(1);
      end else if (cs_in_range && cs_type == SET_CLOSE) begin
        wr_en        = 1'b1;
        wr_data.open = 1'b0;
      end
    end else if (hdr_fire && hdr_in_range) begin
      if (in_type == 8'(PKT_SYN)) begin
        wr_en             = 1'b1;
        wr_data.open      = 1'b1;
        wr_data.nack_sent = 1'b0;
        wr_data.exp       = SEQ_MAX_W'(in_seq + SEQ_W'(1));
        dec_accept        = 1'b1;
        rsp_need          = 1'b1;
      end else if (rd_data.open && is_seq_pkt) begin
        if (d == '0) begin
          dec_accept = 1'b1;
          rsp_need   = 1'b1;
          wr_en      = 1'b1;
          if (in_type == 8'(PKT_FIN)) begin
            wr_data.open = 1'b0;
          end else begin
            wr_data.exp       = SEQ_MAX_W'(exp_cur + SEQ_W'(1));
            wr_data.nack_sent = 1'b0;
          end
        end else if (d[SEQ_W-1]) begin
          rsp_need  = 1'b1;
          rsp_seq_n = exp_cur - SEQ_W'(1);
        end else if (!rd_data.nack_sent) begin
          rsp_need          = 1'b1;
          rsp_type_n        = 8'(PKT_NACK);
          rsp_seq_n         = exp_cur;
          wr_en             = 1'b1;
          wr_data.nack_sent = 1'b1;
        end
      end
    end
  end

  // Decision output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_slot   <= '0;
      out_accept <= 1'b0;
    end else if (hdr_fire) begin
      out_valid  <= 1'b1;
      out_slot   <= in_slot;
      out_accept <= dec_accept;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Response output register; completes independently of the decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_slot  <= '0;
      rsp_seq   <= '0;
      rsp_type  <= '0;
    end else if (hdr_fire && rsp_need) begin
      rsp_valid <= 1'b1;
      rsp_slot  <= in_slot;
      rsp_seq   <= rsp_seq_n;
      rsp_type  <= rsp_type_n;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gbn_rx_seq_tracker.sv
// Directed bench for gbn_rx_seq_tracker: vector table plus hand-written corner sequences.
module tb_gbn_rx_seq_tracker;
  import relnet_pkg::*;

  logic        clk;
  logic        rst;
  logic        conn_set_valid;
  logic        conn_set_ready;
  logic [15:0] conn_set_data;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_slot;
  logic [31:0] in_seq;
  logic [7:0]  in_type;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_slot;
  logic        out_accept;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [9:0]  rsp_slot;
  logic [31:0] rsp_seq;
  logic [7:0]  rsp_type;

  gbn_rx_seq_tracker #(.N_SLOTS(64), .SEQ_W(32)) dut (
    .clk(clk), .rst(rst),
    .conn_set_valid(conn_set_valid), .conn_set_ready(conn_set_ready),
    .conn_set_data(conn_set_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_slot(in_slot),
    .in_seq(in_seq), .in_type(in_type),
    .out_valid(out_valid), .out_ready(out_ready), .out_slot(out_slot),
    .out_accept(out_accept),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_slot(rsp_slot),
    .rsp_seq(rsp_seq), .rsp_type(rsp_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  slot;
    logic [31:0] seq;
    logic [7:0]  typ;
    logic        acc;
    logic        rv;
    logic [7:0]  rt;
    logic [31:0] rs;
  } vec_t;

  vec_t        vt[$];
  int          total = 0;
  int          bad = 0;
  logic        mon_en = 1'b0;
  logic [31:0] mon_q[$];

  localparam logic [7:0] T_ACK  = 8'd1;
  localparam logic [7:0] T_NACK = 8'd2;
  localparam logic [7:0] T_DATA = 8'd3;
  localparam logic [7:0] T_SYN  = 8'd4;
  localparam logic [7:0] T_FIN  = 8'd5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [9:0] slot, input logic [31:0] seq, input logic [7:0] typ,
                     input logic acc, input logic rv, input logic [7:0] rt,
                     input logic [31:0] rs);
    vec_t v;
    v.slot = slot; v.seq = seq; v.typ = typ;
    v.acc = acc; v.rv = rv; v.rt = rt; v.rs = rs;
    vt.push_back(v);
  endtask

  // Called at a negedge; request is taken on the following posedge.
  task automatic conn(input logic [9:0] slot, input logic [5:0] t);
    conn_set_valid = 1'b1;
    conn_set_data  = {slot, t};
    @(negedge clk);
    conn_set_valid = 1'b0;
  endtask

  task automatic hdr(input logic [9:0] slot, input logic [31:0] seq, input logic [7:0] typ);
    in_valid = 1'b1; in_slot = slot; in_seq = seq; in_type = typ;
  endtask

  always @(posedge clk) begin
    if (mon_en && rsp_valid && rsp_ready) mon_q.push_back(rsp_seq);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; conn_set_valid = 1'b0; conn_set_data = '0;
    in_valid = 1'b0; in_slot = '0; in_seq = '0; in_type = '0;
    out_ready = 1'b1; rsp_ready = 1'b1;

    // Slot 20: in-order stream; 21: gap/NACK; 22: duplicate; 40: closed then SYN;
    // 41: sequence wrap; 100: out of range.
    for (int s = 1; s <= 7; s++) add(10'd20, 32'(s), T_DATA, 1, 1, T_ACK, 32'(s));
    for (int s = 1; s <= 3; s++) add(10'd21, 32'(s), T_DATA, 1, 1, T_ACK, 32'(s));
    add(10'd21, 32'd6, T_DATA, 0, 1, T_NACK, 32'd4);
    add(10'd21, 32'd7, T_DATA, 0, 0, 8'd0, 32'd0);
    add(10'd21, 32'd4, T_DATA, 1, 1, T_ACK, 32'd4);
    add(10'd21, 32'd6, T_DATA, 0, 1, T_NACK, 32'd5);
    for (int s = 1; s <= 4; s++) add(10'd22, 32'(s), T_DATA, 1, 1, T_ACK, 32'(s));
    add(10'd22, 32'd3, T_DATA, 0, 1, T_ACK, 32'd4);
    add(10'd40, 32'd1, T_DATA, 0, 0, 8'd0, 32'd0);
    add(10'd40, 32'd0, T_SYN,  1, 1, T_ACK, 32'd0);
    add(10'd40, 32'd1, T_DATA, 1, 1, T_ACK, 32'd1);
    add(10'd20, 32'd8, T_ACK,  0, 0, 8'd0, 32'd0);
    add(10'd20, 32'd9, T_FIN,  0, 1, T_NACK, 32'd8);
    add(10'd20, 32'd8, T_FIN,  1, 1, T_ACK, 32'd8);
    add(10'd20, 32'd9, T_DATA, 0, 0, 8'd0, 32'd0);
    add(10'd41, 32'hFFFF_FFFE, T_SYN,  1, 1, T_ACK, 32'hFFFF_FFFE);
    add(10'd41, 32'hFFFF_FFFF, T_DATA, 1, 1, T_ACK, 32'hFFFF_FFFF);
    add(10'd41, 32'd0,         T_DATA, 1, 1, T_ACK, 32'd0);
    add(10'd41, 32'hFFFF_FFFF, T_DATA, 0, 1, T_ACK, 32'd0);
    add(10'd100, 32'd1, T_DATA, 0, 0, 8'd0, 32'd0);

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_conn_ready", 32'(conn_set_ready), 32'd1);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_slot", 32'(out_slot), 32'd0);
    chk("rel_out_accept", 32'(out_accept), 32'd0);
    chk("rel_rsp_seq", rsp_seq, 32'd0);
    chk("rel_rsp_type", 32'(rsp_type), 32'd0);

    @(negedge clk);
    conn(10'd20, SET_OPEN);
    conn(10'd21, SET_OPEN);
    conn(10'd22, SET_OPEN);
    conn(10'd100, SET_OPEN);

    // Back-to-back vectors: a new header every cycle with both readies high.
    for (int i = 0; i < vt.size(); i++) begin
      hdr(vt[i].slot, vt[i].seq, vt[i].typ);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_out_slot", i), 32'(out_slot), 32'(vt[i].slot));
      chk($sformatf("v%0d_accept", i), 32'(out_accept), 32'(vt[i].acc));
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vt[i].rv));
      if (vt[i].rv) begin
        chk($sformatf("v%0d_rsp_slot", i), 32'(rsp_slot), 32'(vt[i].slot));
        chk($sformatf("v%0d_rsp_type", i), 32'(rsp_type), 32'(vt[i].rt));
        chk($sformatf("v%0d_rsp_seq", i), rsp_seq, vt[i].rs);
      end
    end
    in_valid = 1'b0;

    // OPEN and a same-slot header presented together: header waits one cycle.
    conn_set_valid = 1'b1; conn_set_data = {10'd30, SET_OPEN};
    hdr(10'd30, 32'd1, T_DATA);
    #1;
    chk("open_stall_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    conn_set_valid = 1'b0;
    #1;
    chk("open_then_in_ready", 32'(in_ready), 32'd1);
    chk("open_stall_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("open_then_accept", 32'(out_accept), 32'd1);
    chk("open_then_rsp_seq", rsp_seq, 32'd1);
    chk("open_then_rsp_type", 32'(rsp_type), 32'(T_ACK));

    // Response backpressure with three headers queued behind it.
    conn(10'd31, SET_OPEN);
    mon_en = 1'b1;
    rsp_ready = 1'b0;
    hdr(10'd31, 32'd1, T_DATA);
    @(negedge clk);
    hdr(10'd31, 32'd2, T_DATA);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp_hold%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_hold%0d_rsp_seq", k), rsp_seq, 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    hdr(10'd31, 32'd3, T_DATA);
    rsp_ready = 1'b0;
    #1;
    chk("bp2_rsp_seq", rsp_seq, 32'd2);
    chk("bp2_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("bp2_hold_rsp_seq", rsp_seq, 32'd2);
    rsp_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    chk("bp_rsp_count", 32'(mon_q.size()), 32'd3);
    for (int k = 0; k < mon_q.size(); k++)
      chk($sformatf("bp_rsp%0d_seq", k), mon_q[k], 32'(k + 1));

    // Reset mid-stream with a response pending.
    rsp_ready = 1'b0;
    hdr(10'd30, 32'd2, T_DATA);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_seq", rsp_seq, 32'd0);
    chk("mid_rst_out_slot", 32'(out_slot), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_conn_ready", 32'(conn_set_ready), 32'd1);
    hdr(10'd30, 32'd3, T_DATA);
    @(negedge clk);
    chk("post_rst_s30_accept", 32'(out_accept), 32'd0);
    chk("post_rst_s30_rsp", 32'(rsp_valid), 32'd0);
    hdr(10'd21, 32'd5, T_DATA);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_s21_accept", 32'(out_accept), 32'd0);
    chk("post_rst_s21_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
